// File: rtl/seg_display_scheduler.sv
// Round-robin time-share of the seven-segment display among NREQ clients, DWELL cycles per slot.
// Grant is one cycle after request; optional macro SEG_SCHED_BLANK_EN blanks both7seg while idle.
module seg_display_scheduler #(
    parameter int NREQ  = 4,
    parameter int DWELL = 500,
    parameter int CBITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [14*NREQ-1:0]   pat,
    output logic [NREQ-1:0]      grant,
    output logic [13:0]          both7seg,
    output logic                 seg_valid,
    output logic                 slot_done
);
    localparam int IW = (NREQ <= 2) ? 1 : $clog2(NREQ);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t            state;
    logic [CBITS-1:0]  cnt;
    logic [IW-1:0]     last;
    logic [13:0]       pat_a [NREQ];

    logic              found;
    logic [IW-1:0]     win;
    logic              owner_req;
    logic              expire;

    for (genvar i = 0; i < NREQ; i++) begin : g_pat
        assign pat_a[i] = pat[14*i +: 14];
    end

    // Scan downward so the requester closest after 'last' is the final (winning) assignment.
    always_comb begin
        found = 1'b0;
        win   = last;
        for (int k = NREQ; k >= 1; k--) begin
            logic [IW-1:0] j;
            j = IW'((int'(last) + k) % NREQ);
            if (req[j]) begin
                found = 1'b1;
                win   = j;
            end
        end
    end

    assign owner_req = req[last];
    assign expire    = (state == SHOW) && (cnt == CBITS'(DWELL - 1));
    // Early release must be flagged in the cycle req drops, so this is decoded from current state.
    assign slot_done = (state == SHOW) && (expire || !owner_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            both7seg  <= '0;
            seg_valid <= 1'b0;
            cnt       <= '0;
            last      <= IW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= SHOW;
                        grant     <= NREQ'(1) << win;
                        seg_valid <= 1'b1;
                        cnt       <= '0;
                        last      <= win;
                        both7seg  <= pat_a[win];
                    end
                end
                SHOW: begin
                    if (expire && found) begin
                        grant    <= NREQ'(1) << win;
                        cnt      <= '0;
                        last     <= win;
                        both7seg <= pat_a[win];
                    end else if (expire || !owner_req) begin
                        state     <= IDLE;
                        grant     <= '0;
                        seg_valid <= 1'b0;
                        cnt       <= '0;
`ifdef SEG_SCHED_BLANK_EN
                        both7seg  <= '0;
`endif
                    end else begin
                        cnt      <= cnt + 1'b1;
                        both7seg <= pat_a[last];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler (NREQ=4, DWELL=8) with a grant scoreboard queue.
module tb_seg_display_scheduler;
    localparam int NREQ  = 4;
    localparam int DWELL = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [13:0]       pv [NREQ];
    logic [14*NREQ-1:0] pat;
    logic [NREQ-1:0]   grant;
    logic [13:0]       both7seg;
    logic              seg_valid;
    logic              slot_done;

    int checks   = 0;
    int failures = 0;
    logic [NREQ-1:0] sb [$];

    assign pat = {pv[3], pv[2], pv[1], pv[0]};

    seg_display_scheduler #(.NREQ(NREQ), .DWELL(DWELL), .CBITS(4)) dut (
        .clk(clk), .rst(rst), .req(req), .pat(pat),
        .grant(grant), .both7seg(both7seg), .seg_valid(seg_valid), .slot_done(slot_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full slot: grant constant, slot_done only on the last cycle, pattern tracked.
    task automatic run_slot();
        logic [NREQ-1:0] exp_g;
        logic [13:0]     exp_p;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        exp_g = sb.pop_front();
        exp_p = '0;
        for (int i = 0; i < NREQ; i++) if (exp_g[i]) exp_p = pv[i];
        for (int c = 0; c < DWELL; c++) begin
            @(negedge clk);
            check("slot_grant", 16'(grant), 16'(exp_g));
            check("slot_done", 16'(slot_done), 16'(c == DWELL - 1));
            check("slot_valid", 16'(seg_valid), 16'h1);
            if (c >= 1) check("slot_pattern", 16'(both7seg), 16'(exp_p));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req = '0;
        pv[0] = 14'h0101; pv[1] = 14'h0202; pv[2] = 14'h0404; pv[3] = 14'h0808;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_grant", 16'(grant), 16'h0);
        check("rst_both7seg", 16'(both7seg), 16'h0);
        check("rst_valid", 16'(seg_valid), 16'h0);
        check("rst_slot_done", 16'(slot_done), 16'h0);

        // All requesting: strict rotation, back-to-back slots
        rst = 1'b0;
        req = 4'b1111;
        sb.push_back(4'b0001); sb.push_back(4'b0010); sb.push_back(4'b0100);
        sb.push_back(4'b1000); sb.push_back(4'b0001);
        repeat (5) run_slot();

        // Single requester re-granted each slot, pattern forwarded
        rst = 1'b1; req = '0;
        @(negedge clk);
        rst = 1'b0;
        pv[2] = 14'h1ABC;
        req = 4'b0100;
        sb.push_back(4'b0100); sb.push_back(4'b0100); sb.push_back(4'b0100);
        repeat (3) run_slot();

        // Early release at cnt=3, then another client after a one-cycle gap
        rst = 1'b1; req = '0;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rel_grant", 16'(grant), 16'b0010);
            check("rel_no_done", 16'(slot_done), 16'h0);
        end
        req = 4'b1000;
        #1;
        check("rel_slot_done", 16'(slot_done), 16'h1);
        @(negedge clk);
        check("rel_gap_grant", 16'(grant), 16'h0);
        check("rel_gap_valid", 16'(seg_valid), 16'h0);
        @(negedge clk);
        check("rel_next_grant", 16'(grant), 16'b1000);
        check("rel_next_valid", 16'(seg_valid), 16'h1);

        // Reset mid-slot restarts rotation at client 0
        rst = 1'b1; req = '0;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0010;
        @(negedge clk);
        check("mid_grant", 16'(grant), 16'b0010);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_grant", 16'(grant), 16'h0);
        check("mid_rst_both7seg", 16'(both7seg), 16'h0);
        check("mid_rst_valid", 16'(seg_valid), 16'h0);
        check("mid_rst_done", 16'(slot_done), 16'h0);
        rst = 1'b0;
        req = 4'b1111;
        @(negedge clk);
        check("mid_first_grant", 16'(grant), 16'b0001);

        // Idle display content after a 3FFF slot
        rst = 1'b1; req = '0;
        @(negedge clk);
        rst = 1'b0;
        pv[3] = 14'h3FFF;
        req = 4'b1000;
        @(negedge clk);
        check("idle_grant", 16'(grant), 16'b1000);
        @(negedge clk);
        check("idle_show", 16'(both7seg), 16'h3FFF);
        req = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("idle_valid", 16'(seg_valid), 16'h0);
`ifdef SEG_SCHED_BLANK_EN
            check("idle_both7seg", 16'(both7seg), 16'h0000);
`else
            check("idle_both7seg", 16'(both7seg), 16'h3FFF);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
